fa4: RTL and testbench

Registered 4-bit ripple-carry adder. Adds two 4-bit operands and a carry-in, presenting a 4-bit sum and a carry-out from output registers one clock after the operands are sampled. It is a leaf arithmetic block for wider datapaths. Two instances chained through `c` and `Cin` form an 8-bit adder with one additional cycle per stage.

---
 rtl/fa4.sv | 44 ++++
 tb/tb_fa4.sv | 131 +++++++++++++
 2 files changed

// File: rtl/fa4.sv
// Registered 4-bit ripple-carry adder: {c, s} = A + B + Cin, one cycle after sampling.
// Asynchronous active-low reset clears the output registers.
module fa4 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] A,
  input  logic [3:0] B,
  input  logic       Cin,
  output logic [3:0] s,
  output logic       c
);

  logic [3:0] w_sum;
  logic       w_cout;
  logic [3:0] r_s;
  logic       r_c;

  // Full-adder cells in a ripple chain. A local carry variable avoids a
  // self-referencing carry vector.
  always_comb begin
    logic carry;
    w_sum = 4'h0;
    carry = Cin;
    for (int i = 0; i < 4; i++) begin
      w_sum[i] = A[i] ^ B[i] ^ carry;
      carry    = (A[i] & B[i]) | (carry & (A[i] ^ B[i]));
    end
    w_cout = carry;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s <= 4'h0;
      r_c <= 1'b0;
    end else begin
      r_s <= w_sum;
      r_c <= w_cout;
    end
  end

  assign s = r_s;
  assign c = r_c;

endmodule

// File: tb/tb_fa4.sv
// Directed and exhaustive checks of fa4 against hand-computed values and a 5-bit sum model.
module tb_fa4;

  logic       clk;
  logic       rst_n;
  logic [3:0] A;
  logic [3:0] B;
  logic       Cin;
  logic [3:0] s;
  logic       c;

  int tests;
  int fails;

  fa4 dut (
    .clk  (clk),
    .rst_n(rst_n),
    .A    (A),
    .B    (B),
    .Cin  (Cin),
    .s    (s),
    .c    (c)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [4:0] exp);
    tests++;
    assert ({c, s} === exp) else begin
      fails++;
      $error("FAIL %s: got c=%b s=%h, expected c=%b s=%h", tag, c, s, exp[4], exp[3:0]);
    end
  endtask

  task automatic drive(input logic [3:0] a, input logic [3:0] b, input logic ci);
    A   = a;
    B   = b;
    Cin = ci;
  endtask

  // Advance through one rising edge and settle away from it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [4:0] exp;
    tests = 0;
    fails = 0;
    rst_n = 1'b1;
    drive(4'hF, 4'hF, 1'b1);

    // Reset asserted before any clock edge must clear outputs asynchronously.
    #2 rst_n = 1'b0;
    #1 chk("reset_async_initial", 5'h00);
    for (int k = 0; k < 3; k++) begin
      step();
      chk("reset_hold", 5'h00);
    end

    @(negedge clk);
    rst_n = 1'b1;
    drive(4'h0, 4'h0, 1'b0);
    step();
    chk("zero", 5'h00);
    drive(4'h0, 4'h0, 1'b1);
    step();
    chk("cin_only", 5'h01);

    drive(4'hF, 4'hF, 1'b1);
    step();
    chk("max_cin1", 5'h1F);
    drive(4'hF, 4'hF, 1'b0);
    step();
    chk("max_cin0", 5'h1E);

    drive(4'hF, 4'h0, 1'b1);
    step();
    chk("full_ripple", 5'h10);
    drive(4'h7, 4'h1, 1'b0);
    step();
    chk("ripple_7p1", 5'h08);

    // Back-to-back: outputs must hold the previous result until the next edge.
    drive(4'h3, 4'h4, 1'b0);
    #2 chk("hold_before_edge", 5'h08);
    step();
    chk("b2b_3_4_0", 5'h07);
    drive(4'h9, 4'h9, 1'b1);
    #2 chk("hold_b2b_1", 5'h07);
    step();
    chk("b2b_9_9_1", 5'h13);
    drive(4'h8, 4'h8, 1'b0);
    #2 chk("hold_b2b_2", 5'h13);
    step();
    chk("b2b_8_8_0", 5'h10);

    // Asynchronous reset between edges.
    #2 rst_n = 1'b0;
    #1 chk("reset_async_mid", 5'h00);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 512; i++) begin
      drive(i[8:5], i[4:1], i[0]);
      exp = {1'b0, i[8:5]} + {1'b0, i[4:1]} + {4'h0, i[0]};
      step();
      chk("exhaustive", exp);
      if (i == 300) begin
        // Pulse reset mid-stream: pending result discarded, then resume.
        drive(4'hF, 4'hF, 1'b1);
        #1 rst_n = 1'b0;
        #1 chk("exh_reset_async", 5'h00);
        step();
        chk("exh_reset_hold", 5'h00);
        @(negedge clk);
        rst_n = 1'b1;
        drive(4'hA, 4'h7, 1'b1);
        #1 chk("exh_reset_release_no_edge", 5'h00);
        step();
        chk("exh_reset_resume", 5'h12);
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
